// File: rtl/iob_fp_fpu_sched.sv
// Tagged, queued front-end for a shared FP unit: request FIFO, in-order start/done issue, tagged responses.
// Optional sequenced fused multiply-add (funct 4-7) is enabled by defining FP_FPU_SCHED_FMA_EN.
module iob_fp_fpu_sched #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_funct_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    input  logic [DATA_W-1:0]         req_op_a_i,
    input  logic [DATA_W-1:0]         req_op_b_i,
    input  logic [DATA_W-1:0]         req_op_c_i,
    output logic                      unit_start_o,
    output logic [1:0]                unit_funct_o,
    output logic [DATA_W-1:0]         unit_op_a_o,
    output logic [DATA_W-1:0]         unit_op_b_o,
    input  logic                      unit_done_i,
    input  logic [DATA_W-1:0]         unit_res_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [TAG_W-1:0]          rsp_tag_o,
    output logic [DATA_W-1:0]         rsp_res_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    localparam logic [1:0] U_ADD = 2'd0;
    localparam logic [1:0] U_SUB = 2'd1;
    localparam logic [1:0] U_MUL = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ISSUE2,
        WAIT2,
        RESP
    } state_t;

    typedef struct packed {
        logic [3:0]        funct;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
`ifdef FP_FPU_SCHED_FMA_EN
        logic [DATA_W-1:0] c;
`endif
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              push;
    logic              pop;
    logic              head_ok;
    state_t            state;
    logic [TAG_W-1:0]  op_tag;

`ifdef FP_FPU_SCHED_FMA_EN
    logic [2:0]        op_funct;
    logic [DATA_W-1:0] op_c;
`else
    logic              unused_op_c;
    assign unused_op_c = ^req_op_c_i;
`endif

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign req_ready_o = arst_n_i && (level != FULL_LVL);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == IDLE) && (level != '0);
    assign level_o     = level;
    assign busy_o      = (state != IDLE) || (level != '0);
    assign head        = mem[rd_ptr];

    always_comb begin
        in_entry       = '0;
        in_entry.funct = req_funct_i;
        in_entry.tag   = req_tag_i;
        in_entry.a     = req_op_a_i;
        in_entry.b     = req_op_b_i;
`ifdef FP_FPU_SCHED_FMA_EN
        in_entry.c     = req_op_c_i;
        head_ok        = ~head.funct[3];
`else
        head_ok        = (head.funct[3:2] == 2'b00);
`endif
    end

    // NOTE: FIFO storage has no reset; pointers and level define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state        <= IDLE;
            op_tag       <= '0;
            unit_start_o <= 1'b0;
            unit_funct_o <= U_ADD;
            unit_op_a_o  <= '0;
            unit_op_b_o  <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_tag_o    <= '0;
            rsp_res_o    <= '0;
            rsp_err_o    <= 1'b0;
`ifdef FP_FPU_SCHED_FMA_EN
            op_funct     <= '0;
            op_c         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_tag <= head.tag;
                        if (head_ok) begin
                            state        <= ISSUE;
                            unit_start_o <= 1'b1;
                            unit_funct_o <= head.funct[2] ? U_MUL : head.funct[1:0];
                            unit_op_a_o  <= head.a;
                            unit_op_b_o  <= head.b;
`ifdef FP_FPU_SCHED_FMA_EN
                            op_funct     <= head.funct[2:0];
                            op_c         <= head.c;
`endif
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_tag_o   <= head.tag;
                            rsp_res_o   <= '0;
                            rsp_err_o   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    unit_start_o <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (unit_done_i) begin
`ifdef FP_FPU_SCHED_FMA_EN
                        if (op_funct[2]) begin
                            // Product feeds the second pass; the addend takes operand B.
                            state        <= ISSUE2;
                            unit_start_o <= 1'b1;
                            unit_funct_o <= op_funct[0] ? U_SUB : U_ADD;
                            unit_op_a_o  <= unit_res_i;
                            unit_op_b_o  <= op_c;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_tag_o   <= op_tag;
                            rsp_res_o   <= unit_res_i;
                            rsp_err_o   <= 1'b0;
                        end
`else
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_tag_o   <= op_tag;
                        rsp_res_o   <= unit_res_i;
                        rsp_err_o   <= 1'b0;
`endif
                    end
                end
`ifdef FP_FPU_SCHED_FMA_EN
                ISSUE2: begin
                    unit_start_o <= 1'b0;
                    state        <= WAIT2;
                end
                WAIT2: begin
                    if (unit_done_i) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_tag_o   <= op_tag;
                        rsp_res_o   <= unit_res_i ^ {op_funct[1], {(DATA_W-1){1'b0}}};
                        rsp_err_o   <= 1'b0;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    unit_start_o <= 1'b0;
                    rsp_valid_o  <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_fp_fpu_sched.sv
// Bench for iob_fp_fpu_sched: 3-cycle FP unit model, vector table, directed corner sequences, random traffic.
`timescale 1ns/1ps
module tb_iob_fp_fpu_sched;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;
    localparam int LAT    = 3;

    logic              clk_i = 1'b0;
    logic              arst_n_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [3:0]        req_funct_i = '0;
    logic [TAG_W-1:0]  req_tag_i = '0;
    logic [31:0]       req_op_a_i = '0;
    logic [31:0]       req_op_b_i = '0;
    logic [31:0]       req_op_c_i = '0;
    logic              unit_start_o;
    logic [1:0]        unit_funct_o;
    logic [31:0]       unit_op_a_o;
    logic [31:0]       unit_op_b_o;
    logic              unit_done_i = 1'b0;
    logic [31:0]       unit_res_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic [31:0]       rsp_res_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic [2:0]        level_o;

    iob_fp_fpu_sched #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct_i(req_funct_i),
        .req_tag_i(req_tag_i), .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_op_c_i(req_op_c_i),
        .unit_start_o(unit_start_o), .unit_funct_o(unit_funct_o),
        .unit_op_a_o(unit_op_a_o), .unit_op_b_o(unit_op_b_o),
        .unit_done_i(unit_done_i), .unit_res_i(unit_res_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tag_o(rsp_tag_o),
        .rsp_res_o(rsp_res_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             err;
    } rsp_t;

    typedef struct {
        logic [3:0]       f;
        logic [TAG_W-1:0] t;
        logic [31:0]      a, b, c;
        logic [31:0]      res;
        logic             err;
        int               starts;
        logic [1:0]       f0, f1;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    rsp_t       got_q[$];
    rsp_t       exp_q[$];
    logic [1:0] start_fq[$];
    int         start_cnt = 0;
    int         ucnt = 0;
    logic [31:0] ures = '0;
    bit         inject_done = 0;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Integer to single-precision bits (exact for |v| < 2^24).
    function automatic logic [31:0] enc(input int v);
        logic [31:0] m;
        int p;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        return {(v < 0), 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    function automatic real dec(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        r = real'({1'b1, x[22:0]});
        e = int'(x[30:23]) - 150;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        return x[31] ? -r : r;
    endfunction

    // Transaction-level expectation straight from the function codes.
    function automatic rsp_t ref_rsp(input logic [3:0] f, input logic [TAG_W-1:0] t, input int a, b, c);
        rsp_t x;
        x.tag = t;
        x.err = 1'b0;
        case (f)
            4'd0: x.res = enc(a + b);
            4'd1: x.res = enc(a - b);
            4'd2: x.res = enc(a * b);
            4'd3: x.res = enc(a / b);
`ifdef FP_FPU_SCHED_FMA_EN
            4'd4: x.res = enc(a * b + c);
            4'd5: x.res = enc(a * b - c);
            4'd6: x.res = enc(a * b + c) ^ 32'h8000_0000;
            4'd7: x.res = enc(a * b - c) ^ 32'h8000_0000;
`endif
            default: begin x.res = '0; x.err = 1'b1; end
        endcase
        return x;
    endfunction

    // Fixed-latency FP unit plus start tracker.
    always @(negedge clk_i) begin : unit_model
        real ra, rb, rr;
        unit_done_i = 1'b0;
        if (!arst_n_i) ucnt = 0;
        if (inject_done) begin
            unit_done_i = 1'b1;
            unit_res_i  = 32'h1234_5678;
            inject_done = 0;
        end
        if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) begin
                unit_done_i = 1'b1;
                unit_res_i  = ures;
            end
        end
        if (unit_start_o) begin
            start_cnt++;
            start_fq.push_back(unit_funct_o);
            ra = dec(unit_op_a_o);
            rb = dec(unit_op_b_o);
            case (unit_funct_o)
                2'd0:    rr = ra + rb;
                2'd1:    rr = ra - rb;
                2'd2:    rr = ra * rb;
                default: rr = ra / rb;
            endcase
            ures = enc($rtoi(rr));
            ucnt = LAT;
        end
    end

    always @(negedge clk_i) begin
        if (arst_n_i && rsp_valid_o && rsp_ready_i) got_q.push_back({rsp_tag_o, rsp_res_o, rsp_err_o});
    end

    // Called and returns just after a rising edge.
    task automatic push(input logic [3:0] f, input logic [TAG_W-1:0] t, input logic [31:0] a, b, c);
        bit ok = 0;
        int n = 0;
        req_valid_i = 1'b1;
        req_funct_i = f;
        req_tag_i   = t;
        req_op_a_i  = a;
        req_op_b_i  = b;
        req_op_c_i  = c;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            ok = req_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        req_valid_i = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("rsp_count", got_q.size(), n);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        int   s0;

        vecs[0] = '{4'd0, 4'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4040_0000, 1'b0, 1, 2'd0, 2'd0};
        vecs[1] = '{4'd1, 4'd1, 32'h40A0_0000, 32'h4000_0000, 32'h0, 32'h4040_0000, 1'b0, 1, 2'd1, 2'd0};
        vecs[2] = '{4'd2, 4'd2, 32'h4040_0000, 32'hC000_0000, 32'h0, 32'hC0C0_0000, 1'b0, 1, 2'd2, 2'd0};
        vecs[3] = '{4'd3, 4'd4, 32'h4100_0000, 32'h4080_0000, 32'h0, 32'h4000_0000, 1'b0, 1, 2'd3, 2'd0};
        vecs[4] = '{4'd9, 4'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0, 1'b1, 0, 2'd0, 2'd0};
        vecs[5] = '{4'd15, 4'd15, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0, 1'b1, 0, 2'd0, 2'd0};
`ifdef FP_FPU_SCHED_FMA_EN
        vecs[6] = '{4'd4, 4'd6, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h40E0_0000, 1'b0, 2, 2'd2, 2'd0};
        vecs[7] = '{4'd7, 4'd7, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'hC0A0_0000, 1'b0, 2, 2'd2, 2'd1};
`else
        vecs[6] = '{4'd4, 4'd6, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0, 1'b1, 0, 2'd0, 2'd0};
        vecs[7] = '{4'd7, 4'd7, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0, 1'b1, 0, 2'd0, 2'd0};
`endif

        // Reset state.
        #2;
        check("rst_ctrl", {req_ready_o, unit_start_o, unit_funct_o, rsp_valid_o, rsp_err_o, busy_o, level_o, rsp_tag_o}, 0);
        check("rst_data", {unit_op_a_o, unit_op_b_o}, 0);
        check("rst_res", rsp_res_o, 0);
        cycles(3);
        arst_n_i = 1'b1;
        #1;
        check("rdy_after_rst", req_ready_o, 1);
        check("level_after_rst", level_o, 0);

        // Vector table, one request at a time.
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            got_q.delete();
            start_fq.delete();
            s0 = start_cnt;
            push(vecs[i].f, vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].c);
            wait_rsp(1, 100);
            r = (got_q.size() > 0) ? got_q.pop_front() : '0;
            check($sformatf("vec%0d_tag", i), r.tag, vecs[i].t);
            check($sformatf("vec%0d_res", i), r.res, vecs[i].res);
            check($sformatf("vec%0d_err", i), r.err, vecs[i].err);
            cycles(2);
            check($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].starts);
            if (start_fq.size() > 0) check($sformatf("vec%0d_f0", i), start_fq[0], vecs[i].f0);
            if (start_fq.size() > 1) check($sformatf("vec%0d_f1", i), start_fq[1], vecs[i].f1);
            check($sformatf("vec%0d_level", i), level_o, 0);
            check($sformatf("vec%0d_busy", i), busy_o, 0);
        end

        // Backpressure: tag 0 parks in RESP, tags 1-4 fill the FIFO, tag 5 stalls.
        got_q.delete();
        rsp_ready_i = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) push(4'd2, TAG_W'(t), enc(t + 1), enc(3), 32'h0);
            end
            begin
                cycles(14);
                check("bp_level", level_o, 4);
                check("bp_ready", req_ready_o, 0);
                check("bp_rsp_valid", rsp_valid_o, 1);
                check("bp_rsp_tag", rsp_tag_o, 0);
                rsp_ready_i = 1'b1;
            end
        join
        wait_rsp(6, 300);
        for (int t = 0; t < 6; t++) begin
            r = (got_q.size() > 0) ? got_q.pop_front() : '0;
            check($sformatf("bp_tag%0d", t), r.tag, t);
            check($sformatf("bp_res%0d", t), r.res, enc(3 * (t + 1)));
        end
        cycles(3);
        check("bp_drained", got_q.size(), 0);

        // Reset while in WAIT with two entries queued.
        got_q.delete();
        push(4'd0, 4'd1, enc(1), enc(2), 32'h0);
        push(4'd0, 4'd2, enc(1), enc(2), 32'h0);
        push(4'd0, 4'd3, enc(1), enc(2), 32'h0);
        check("pre_rst_level", level_o, 2);
        arst_n_i = 1'b0;
        #1;
        check("mid_rst_ctrl", {req_ready_o, unit_start_o, unit_funct_o, rsp_valid_o, rsp_err_o, busy_o, level_o, rsp_tag_o}, 0);
        check("mid_rst_data", {unit_op_a_o, unit_op_b_o}, 0);
        cycles(3);
        arst_n_i = 1'b1;
        got_q.delete();
        s0 = start_cnt;
        cycles(2);
        inject_done = 1;
        cycles(10);
        check("late_done_rsp", got_q.size(), 0);
        check("late_done_valid", rsp_valid_o, 0);
        check("late_done_starts", start_cnt - s0, 0);
        check("late_done_level", level_o, 0);
        push(4'd0, 4'd7, 32'h3F80_0000, 32'h4000_0000, 32'h0);
        wait_rsp(1, 100);
        r = (got_q.size() > 0) ? got_q.pop_front() : '0;
        check("post_rst_rsp", r, {4'd7, 32'h4040_0000, 1'b0});

        // Random traffic with random response backpressure.
        got_q.delete();
        exp_q.delete();
        begin
            bit done = 0;
            int matched = 0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        logic [3:0]       f;
                        logic [TAG_W-1:0] t;
                        int a, b, c;
                        f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                        t = TAG_W'($urandom_range(0, 15));
                        b = $urandom_range(1, 8) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                        a = $urandom_range(1, 20) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                        c = $urandom_range(1, 20) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                        if (f == 4'd3) a = a * b;
                        exp_q.push_back(ref_rsp(f, t, a, b, c));
                        push(f, t, enc(a), enc(b), enc(c));
                        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
                    end
                end
                begin
                    int k = 0;
                    while (!done && k < 4000) begin
                        @(posedge clk_i);
                        #1;
                        rsp_ready_i = ($urandom_range(0, 3) != 0);
                        k++;
                    end
                end
                begin
                    int k = 0;
                    while (matched < 40 && k < 4000) begin
                        @(posedge clk_i);
                        #1;
                        k++;
                        while (got_q.size() > 0 && exp_q.size() > 0) begin
                            rsp_t g, e;
                            g = got_q.pop_front();
                            e = exp_q.pop_front();
                            check($sformatf("rnd%0d_rsp", matched), g, e);
                            matched++;
                        end
                    end
                    done = 1;
                end
            join
            check("rnd_matched", matched, 40);
            check("rnd_extra", got_q.size(), 0);
        end
        rsp_ready_i = 1'b1;
        cycles(4);
        check("final_level", level_o, 0);
        check("final_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_fp_fpu_sched.md
Name: iob_fp_fpu_sched

Overview:
- Tagged, queued front-end for a shared floating-point arithmetic unit.
- Accepts requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues them in order to an external unit through a start/done interface, and returns tagged results over a valid/ready response port.
- Successor to the single-shot FPU dispatcher: adds queueing, tags, backpressure, error reporting, and optional sequenced fused multiply-add.

Parameters:
- DATA_W, 32: operand/result width; sign bit is DATA_W-1.
- TAG_W, 4: request tag width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready (= FIFO not full)
- req_funct_i  in  4  0 add, 1 sub, 2 mul, 3 div, 4 madd, 5 msub, 6 nmadd, 7 nmsub, 8-15 unsupported
- req_tag_i  in  TAG_W  request tag
- req_op_a_i, req_op_b_i, req_op_c_i  in  DATA_W each  operands
- unit_start_o  out  1  one-cycle start pulse to unit
- unit_funct_o  out  2  0 add, 1 sub, 2 mul, 3 div
- unit_op_a_o, unit_op_b_o  out  DATA_W each  unit operands, held stable from start until done
- unit_done_i  in  1  unit result valid
- unit_res_i  in  DATA_W  unit result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_tag_o  out  TAG_W  tag of response
- rsp_res_o  out  DATA_W  result
- rsp_err_o  out  1  unsupported function
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (arst_n_i low, asynchronous) clears:
  - FIFO pointers and level_o to 0.
  - FSM to IDLE.
  - All outputs to 0, except req_ready_o=1 after reset release.
- FIFO write: req_valid_i & req_ready_o.
  - req_ready_o = level_o != DEPTH; there is no same-cycle pass-through when full.
  - Simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
- IDLE: if FIFO non-empty, pop the head into the operation register.
  - funct 8-15 (and 4-7 without the optional feature): go to RESP with res=0, err=1. No unit_start_o.
  - Otherwise go to ISSUE.
- ISSUE: unit_start_o=1 for exactly this cycle.
  - unit_funct_o = funct[1:0] for funct 0-3, or mul (2) for funct 4-7.
  - op_a/op_b = a/b.
  - Then go to WAIT.
- WAIT: unit_done_i is sampled only in WAIT (never in the ISSUE cycle).
  - On done, capture unit_res_i and go to RESP, or to ISSUE2 for a fused op.
- ISSUE2/WAIT2: second pass of a fused op (see Optional Feature); same rules as ISSUE/WAIT.
- RESP: rsp_valid_o=1, with tag/res/err held stable until rsp_ready_i.
  - On accept, go to IDLE; the next pop occurs in the following cycle.
  - The FIFO keeps accepting requests while in RESP.
- Minimum latency for a 1-cycle unit: accept at cycle 0, pop cycle 1, start cycle 2, done cycle 3, rsp_valid_o cycle 4.
- Responses are returned in strict request order. Tags are passed through unmodified.
- unit_done_i outside WAIT/WAIT2 is ignored, including a late done after reset.

Optional Feature:
- Macro FP_FPU_SCHED_FMA_EN.
- Defined: funct 4-7 are supported as two sequenced unit ops.
  - First op: mul(a,b) -> p.
  - Second op (ISSUE2): add(p,c) for madd/nmadd, sub(p,c) for msub/nmsub.
  - nmadd/nmsub invert bit DATA_W-1 of the final result.
  - Two unit_start_o pulses per request; err=0.
- Undefined: funct 4-7 are handled as unsupported (err=1, res=0, no start).
  - ISSUE2/WAIT2 logic is compiled out.

Test Plan (bench models the unit as a fixed 3-cycle IEEE-754 single-precision unit unless stated):
- Add: add tag 5, a=0x3F800000, b=0x40000000 -> single unit_start_o pulse with funct 0; rsp tag 5, res 0x40400000, err 0; level_o returns to 0.
- Backpressure: hold rsp_ready_i=0, push 6 back-to-back mul requests, tags 0-5.
  - Tag 0 parks in RESP; tags 1-4 fill the FIFO; req_ready_o=0 with level_o=4, so tag 5 stalls.
  - Release rsp_ready_i -> responses tags 0,1,2,3,4,5 in order, no loss or duplication.
- Unsupported: funct 9, tag 3 -> rsp err 1, res 0, tag 3; unit_start_o never asserted.
- Fused op (macro defined): madd a=0x40000000, b=0x40400000, c=0x3F800000 -> start pulses mul then add; res 0x40E00000.
  - nmsub with the same operands -> res 0xC0A00000.
  - Macro undefined: same madd -> err 1, no start.
- Reset mid-operation: assert arst_n_i low in WAIT with 2 entries queued -> all outputs 0, level_o 0 immediately.
  - A unit_done_i pulse 2 cycles after release produces no response.
  - A new add request then completes normally.
